pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry valid/ready pipeline stage (main register + skid register).
// Optional stall counter output is built only when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_WIDTH  = 160,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PAYLOAD_WIDTH-1:0] out_data_o
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
`endif
);

  if (PAYLOAD_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipe_stage_reg: PAYLOAD_WIDTH and CNT_WIDTH must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                   r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [PAYLOAD_WIDTH-1:0] r_main;
  logic [PAYLOAD_WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;

  // Handshake fires use only registered ready/valid, so no ready->ready path exists.
  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready_i;

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;

  // State, flags and payload registers; flush overrides every transition.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b1;
            r_main      <= in_data_i;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data_i;
          end else if (w_in_fire) begin
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
            r_skid     <= in_data_i;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
              r_main <= '0;
            end
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state <= ST_BUSY;
            r_main  <= r_skid;
            if (CLEAR_ON_FLUSH) begin
              r_skid <= '0;
            end
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_main      <= '0;
          r_skid      <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Saturating count of cycles where an entry waits on downstream; flush does not clear it.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready_i && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard on the default build plus a
// CLEAR_ON_FLUSH=0 / CNT_WIDTH=4 instance for retention and stall-counter checks.
module tb_pipe_stage_reg;

  localparam int unsigned W   = 160;
  localparam int unsigned W2  = 8;
  localparam int unsigned CW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic          flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W2-1:0] in_data2, out_data2;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]    stall_cnt;
  logic [CW2-1:0] stall_cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] sb_q[$];

  pipe_stage_reg dut (
    .cpu_clk     (clk),
    .cpu_rst_n   (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  pipe_stage_reg #(
    .PAYLOAD_WIDTH  (W2),
    .CLEAR_ON_FLUSH (1'b0),
    .CNT_WIDTH      (CW2)
  ) dut2 (
    .cpu_clk     (clk),
    .cpu_rst_n   (rst_n),
    .flush_i     (flush2),
    .in_valid_i  (in_valid2),
    .in_ready_o  (in_ready2),
    .in_data_i   (in_data2),
    .out_valid_o (out_valid2),
    .out_ready_i (out_ready2),
    .out_data_o  (out_data2)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt2)
`endif
  );

  // Scoreboard: pop/compare on output fire, idle-zero check, then push on input fire.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: got %h, expected no output", out_data);
        end else begin
          logic [W-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            n_errors++;
            $display("FAIL sb_data: got %h, expected %h", out_data, exp_d);
          end
        end
      end
      if (!out_valid) begin
        n_checks++;
        if (out_data !== '0) begin
          n_errors++;
          $display("FAIL idle_zero: got %h, expected 0", out_data);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b data=%h, expected 0 0 0",
               in_ready, out_valid, out_data);
    end
`ifdef PIPE_STAGE_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd0 || stall_cnt2 !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %0d/%0d, expected 0/0", stall_cnt, stall_cnt2);
    end
`endif
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge: got %b, expected 0", in_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_edge: got %b/%b, expected 1/1", in_ready, in_ready2);
    end
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_data  = (i < 3) ? W'(i + 1) : '0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_ready[%0d]: got %b, expected 1", i, in_ready);
      end
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== W'(i)) begin
          n_errors++;
          $display("FAIL stream_out[%0d]: valid=%b data=%h, expected 1 %h", i, out_valid, out_data, W'(i));
        end
      end
      if (i == 4) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL stream_end: valid=%b, expected 0", out_valid);
        end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Leaves DUT FULL with 0xA in main and 0xB in skid.
  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'(8'hA);
    step();
    in_data = W'(8'hB);
    step();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_skid();
    fill_ab();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'(8'hA)) begin
        n_errors++;
        $display("FAIL skid_full[%0d]: ready=%b valid=%b data=%h, expected 0 1 a",
                 i, in_ready, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (i < 2 && (out_valid !== 1'b1 || out_data !== W'(8'hA + i))) begin
        n_errors++;
        $display("FAIL skid_drain[%0d]: valid=%b data=%h, expected 1 %h", i, out_valid, out_data, W'(8'hA + i));
      end else if (i == 2 && (out_valid !== 1'b0 || in_ready !== 1'b1)) begin
        n_errors++;
        $display("FAIL skid_empty: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
      end
      step();
    end
  endtask

  task automatic test_flush();
    fill_ab();
    flush = 1'b1; in_valid = 1'b1; in_data = W'(8'hC);
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: valid=%b data=%h ready=%b, expected 0 0 1", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_no_c[%0d]: valid=%b data=%h, expected valid 0", i, out_valid, out_data);
      end
    end
    step();
  endtask

  task automatic test_stall_cnt();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 8'h7;
    step();
    in_valid2 = 1'b0;
`ifdef PIPE_STAGE_STALL_CNT_EN
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (stall_cnt2 !== CW2'((k > 15) ? 15 : k)) begin
        n_errors++;
        $display("FAIL stall_cnt[%0d]: got %0d, expected %0d", k, stall_cnt2, (k > 15) ? 15 : k);
      end
    end
    #1;
`else
    repeat (2) step();
`endif
    flush2 = 1'b1;
    step();
    flush2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_flush_valid: got %b, expected 0", out_valid2);
    end
`ifdef PIPE_STAGE_STALL_CNT_EN
    n_checks++;
    if (stall_cnt2 !== 4'd15) begin
      n_errors++;
      $display("FAIL stall_after_flush: got %0d, expected 15", stall_cnt2);
    end
`endif
    step();
  endtask

  task automatic test_flush_retain();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 8'h5;
    step();
    in_valid2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 8'h5) begin
      n_errors++;
      $display("FAIL retain_busy: valid=%b data=%h, expected 1 05", out_valid2, out_data2);
    end
    step();
    flush2 = 1'b1;
    step();
    flush2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid2 !== 1'b0 || out_data2 !== 8'h5 || in_ready2 !== 1'b1) begin
      n_errors++;
      $display("FAIL retain_flush: valid=%b data=%h ready=%b, expected 0 05 1", out_valid2, out_data2, in_ready2);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_drain: pending=%0d valid=%b, expected 0 0", sb_q.size(), out_valid);
    end
    step();
  endtask

  task automatic test_async_reset();
    fill_ab();
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: valid=%b data=%h ready=%b, expected 0 0 0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall_cnt();
    test_flush_retain();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
